// File: rtl/usbf_scan_seq.sv
// Scan-vector sequencer for the USB function core test harness: shifts stimulus
// into the input chain, settles, captures, then streams the captured response out.
module usbf_scan_seq #(
  parameter int IN_LEN     = 125,
  parameter int OUT_LEN    = 121,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic abort_i,
  input  logic vec_valid_i,
  input  logic vec_bit_i,
  output logic vec_ready_o,
  output logic in_shift_o,
  output logic out_shift_o,
  output logic load_o,
  input  logic scan_out_i,
  output logic res_valid_o,
  output logic res_bit_o,
  input  logic res_ready_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_LEN - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_SETTLE,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Abort forces every output low in the cycle it is seen, so nothing is accepted or shifted.
  assign vec_ready_o = ~abort_i & (state_q == S_SHIFT_IN);
  assign in_shift_o  = vec_ready_o & vec_valid_i;
  assign load_o      = ~abort_i & (state_q == S_CAPTURE);
  assign res_valid_o = ~abort_i & (state_q == S_SHIFT_OUT);
  assign out_shift_o = load_o | (res_valid_o & res_ready_i);
  assign res_bit_o   = res_valid_o & scan_out_i;
  assign busy_o      = ~abort_i & (state_q != S_IDLE);
  assign done_o      = ~abort_i & (state_q == S_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (abort_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (start_i) state_q <= S_SHIFT_IN;
        end
        S_SHIFT_IN: begin
          if (vec_valid_i) begin
            if (cnt_q == IN_LAST) begin
              cnt_q   <= '0;
              state_q <= (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q == SET_LAST) begin
            cnt_q   <= '0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          cnt_q   <= '0;
          state_q <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          if (res_ready_i) begin
            if (cnt_q == OUT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
